cmd_frame_engine: RTL and testbench
===================================

Name: cmd_frame_engine

Overview:
Parametrised command-frame engine that replaces the hard-wired verb/arg1..arg3 front end of the token-dispenser top level. It collects a verb byte plus N_ARGS argument bytes from the UART receiver and decodes the verb. It then drives the UART transmitter with a reply sequence and launches N_CH dispenser channels. It adds behaviour the first-generation FSM lacked: an inter-byte frame timeout, NAK replies for bad or aborted frames, and a dispense watchdog.

Parameters:
N_ARGS, 3, argument bytes per frame (1..8)
N_CH, 3, dispenser channels; N_CH <= N_ARGS; channel k count = arg k
BYTE_TIMEOUT, 5_000_000, max clk50m cycles between bytes of one frame (100 ms)
DISP_TIMEOUT, 500_000_000, max cycles waiting for all disp_done (10 s)
V_PING, 8'h02, ping verb
V_GO, 8'h06, dispense verb

Ports:
clk50m  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
rx_ready  in  1  one-cycle strobe; rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle transmit strobe (registered)
tx_data  out  8  byte to send; registered, stable from tx_start until tx_busy falls
disp_start  out  1  one-cycle pulse to all channels
disp_count  out  8*N_CH  channel k count at bits [8k+7:8k]; registered, held until next GO
disp_done  in  N_CH  per-channel done level
verb_out  out  8  last decoded verb, for HEX display
args_out  out  8*N_ARGS  last frame arguments, arg0 in the LSBs
state_out  out  4  current state encoding
frame_err  out  1  one-cycle pulse on every NAK

Behaviour:
Reset (reset=0, async): state=ANNOUNCE; all outputs 0; arg/verb registers 0; timers 0.
All outputs are registered; there is no combinational path from inputs to outputs.

TX sub-sequence (used for every reply byte):
- Cycle 0: tx_start=1, tx_data=code.
- Enter TXW; ignore tx_busy in the first TXW cycle.
- Leave TXW on the first later cycle with tx_busy=0, then go to the stored return state.

States:
- ANNOUNCE: send 8'h01 -> IDLE.
- IDLE: wait for rx_ready. On rx_ready, latch verb, clear arg index and timer -> ARGS. Stay in IDLE if N_ARGS=0 is ever allowed (not legal here).
- ARGS:
  - On rx_ready: store the byte at the current index and increment the index; the timer resets on every byte.
  - When index reaches N_ARGS -> DECODE.
  - If the timer reaches BYTE_TIMEOUT with no byte: discard the frame, send NAK 8'h0F, pulse frame_err -> IDLE.
- DECODE (1 cycle):
  - verb==V_PING -> send PONG 8'h05 -> IDLE.
  - verb==V_GO -> DISPATCH.
  - Any other verb -> send NAK -> IDLE.
- DISPATCH:
  - Load disp_count from args 0..N_CH-1.
  - Pulse disp_start in the same cycle.
  - Send ACK 8'h04, then echo the verb byte -> WAIT_DISP.
  - disp_done is not sampled until at least 2 cycles after disp_start.
- WAIT_DISP:
  - When &disp_done==1: send DONE 8'h03, then CONFIRM 8'h00 -> IDLE.
  - If the watchdog reaches DISP_TIMEOUT: send NAK, pulse frame_err -> IDLE.
- verb_out and args_out update only on a complete frame (entry to DECODE). Aborted frames leave them unchanged.

Boundary rules:
- rx_ready outside IDLE/ARGS (during TX, DISPATCH or WAIT_DISP) is dropped, not queued.
- rx_ready arriving in the same cycle as the timeout expires: the byte wins and the timer restarts.
- A count of 0 is legal. The channel reports done immediately; the engine does not special-case it.
- Reset asserted mid-frame or mid-TX: immediate return to reset values; ANNOUNCE is resent after release.
- Timer widths are sized by $clog2 of their parameter; the timers saturate and never wrap.
- An illegal state encoding goes to ANNOUNCE.

Test Plan:
- Release reset with tx_busy modelled at 10 cycles per byte -> exactly one tx_start carrying 8'h01, then state IDLE.
- Send bytes 02,00,00,00 -> one tx_start carrying 8'h05; verb_out=02; no disp_start.
- Send 06,03,01,02 -> disp_start pulse with disp_count={02,01,03}; tx sends 04 then 06. Raise disp_done=3'b111 -> tx sends 03 then 00.
- Send 06,05 then idle for BYTE_TIMEOUT cycles (set to 100 in the bench) -> tx sends 0F; frame_err pulses; args_out unchanged. The next full 02 frame -> 05.
- Send 7A,00,00,00 -> tx sends 0F; frame_err=1; disp_start never asserted.
- GO with disp_done held 0 and DISP_TIMEOUT=1000 -> after ACK and echo, NAK at ~1000 cycles. Also assert reset mid-WAIT_DISP -> outputs return to 0 and 01 is resent.

Source files
------------

// File: rtl/cmd_frame_engine.sv
// Command-frame engine for the token dispenser.
// It collects a verb byte and N_ARGS argument bytes, decodes the verb and sends the
// reply bytes. For a GO verb it launches the N_CH dispenser channels.
// Inter-byte timeouts, unknown verbs and dispense watchdog expiry are answered with NAK.
module cmd_frame_engine #(
  parameter int          N_ARGS       = 3,
  parameter int          N_CH         = 3,
  parameter int          BYTE_TIMEOUT = 5_000_000,
  parameter int          DISP_TIMEOUT = 500_000_000,
  parameter logic [7:0]  V_PING       = 8'h02,
  parameter logic [7:0]  V_GO         = 8'h06
) (
  input  logic                  clk50m,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  disp_start,
  output logic [8*N_CH-1:0]     disp_count,
  input  logic [N_CH-1:0]       disp_done,
  output logic [7:0]            verb_out,
  output logic [8*N_ARGS-1:0]   args_out,
  output logic [3:0]            state_out,
  output logic                  frame_err
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int WD_W = $clog2(DISP_TIMEOUT + 1);
  localparam int IX_W = $clog2(N_ARGS + 1);

  localparam logic [BT_W-1:0] BT_MAX  = BT_W'(BYTE_TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(DISP_TIMEOUT);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(N_ARGS - 1);

  localparam logic [7:0] C_CONFIRM = 8'h00;
  localparam logic [7:0] C_HELLO   = 8'h01;
  localparam logic [7:0] C_DONE    = 8'h03;
  localparam logic [7:0] C_ACK     = 8'h04;
  localparam logic [7:0] C_PONG    = 8'h05;
  localparam logic [7:0] C_NAK     = 8'h0F;

  typedef enum logic [3:0] {
    S_ANNOUNCE  = 4'd0,
    S_IDLE      = 4'd1,
    S_ARGS      = 4'd2,
    S_DECODE    = 4'd3,
    S_DISPATCH  = 4'd4,
    S_ECHO      = 4'd5,
    S_WAIT_DISP = 4'd6,
    S_CONFIRM   = 4'd7,
    S_TXW       = 4'd8
  } state_t;

  state_t               state, state_n;
  state_t               ret_state, ret_state_n;
  logic [IX_W-1:0]      idx, idx_n;
  logic [BT_W-1:0]      btmr, btmr_n;
  logic [WD_W-1:0]      wtmr, wtmr_n;
  logic [7:0]           verb_buf, verb_buf_n;
  logic [8*N_ARGS-1:0]  arg_buf, arg_buf_n;
  logic                 tx_start_n;
  logic [7:0]           tx_data_n;
  logic                 disp_start_n;
  logic [8*N_CH-1:0]    disp_count_n;
  logic [7:0]           verb_out_n;
  logic [8*N_ARGS-1:0]  args_out_n;
  logic                 frame_err_n;

  // Saturating increments: the timers stop at their limit instead of wrapping.
  function automatic logic [BT_W-1:0] sat_inc_bt(input logic [BT_W-1:0] v);
    return (v == BT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + 1'b1;
  endfunction

  assign state_out = state;

  // Next-state and next-output logic. A reply byte is launched by registering
  // tx_start/tx_data, moving to TXW and storing the state to resume afterwards.
  always_comb begin
    state_n      = state;
    ret_state_n  = ret_state;
    idx_n        = idx;
    btmr_n       = btmr;
    wtmr_n       = wtmr;
    verb_buf_n   = verb_buf;
    arg_buf_n    = arg_buf;
    tx_start_n   = 1'b0;
    tx_data_n    = tx_data;
    disp_start_n = 1'b0;
    disp_count_n = disp_count;
    verb_out_n   = verb_out;
    args_out_n   = args_out;
    frame_err_n  = 1'b0;

    case (state)
      S_ANNOUNCE: begin
        tx_start_n  = 1'b1;
        tx_data_n   = C_HELLO;
        ret_state_n = S_IDLE;
        state_n     = S_TXW;
      end

      S_IDLE: begin
        if (rx_ready) begin
          verb_buf_n = rx_data;
          idx_n      = '0;
          btmr_n     = '0;
          state_n    = S_ARGS;
        end
      end

      S_ARGS: begin
        // A byte arriving on the expiry cycle still counts and restarts the timer.
        if (rx_ready) begin
          for (int k = 0; k < N_ARGS; k++) begin
            if (idx == IX_W'(k)) arg_buf_n[8*k +: 8] = rx_data;
          end
          idx_n  = idx + 1'b1;
          btmr_n = '0;
          if (idx == IX_LAST) begin
            args_out_n = arg_buf_n;
            verb_out_n = verb_buf;
            state_n    = S_DECODE;
          end
        end else if (btmr == BT_MAX) begin
          tx_start_n  = 1'b1;
          tx_data_n   = C_NAK;
          frame_err_n = 1'b1;
          ret_state_n = S_IDLE;
          state_n     = S_TXW;
        end else begin
          btmr_n = sat_inc_bt(btmr);
        end
      end

      S_DECODE: begin
        if (verb_out == V_PING) begin
          tx_start_n  = 1'b1;
          tx_data_n   = C_PONG;
          ret_state_n = S_IDLE;
          state_n     = S_TXW;
        end else if (verb_out == V_GO) begin
          state_n = S_DISPATCH;
        end else begin
          tx_start_n  = 1'b1;
          tx_data_n   = C_NAK;
          frame_err_n = 1'b1;
          ret_state_n = S_IDLE;
          state_n     = S_TXW;
        end
      end

      S_DISPATCH: begin
        disp_count_n = args_out[8*N_CH-1:0];
        disp_start_n = 1'b1;
        wtmr_n       = '0;
        tx_start_n   = 1'b1;
        tx_data_n    = C_ACK;
        ret_state_n  = S_ECHO;
        state_n      = S_TXW;
      end

      S_ECHO: begin
        tx_start_n  = 1'b1;
        tx_data_n   = verb_out;
        ret_state_n = S_WAIT_DISP;
        state_n     = S_TXW;
      end

      S_WAIT_DISP: begin
        if (&disp_done) begin
          tx_start_n  = 1'b1;
          tx_data_n   = C_DONE;
          ret_state_n = S_CONFIRM;
          state_n     = S_TXW;
        end else if (wtmr == WD_MAX) begin
          tx_start_n  = 1'b1;
          tx_data_n   = C_NAK;
          frame_err_n = 1'b1;
          ret_state_n = S_IDLE;
          state_n     = S_TXW;
        end else begin
          wtmr_n = sat_inc_wd(wtmr);
        end
      end

      S_CONFIRM: begin
        tx_start_n  = 1'b1;
        tx_data_n   = C_CONFIRM;
        ret_state_n = S_IDLE;
        state_n     = S_TXW;
      end

      S_TXW: begin
        // tx_start is still high in the first TXW cycle, before the transmitter
        // has had a chance to raise tx_busy, so that cycle is skipped.
        if (!tx_start && !tx_busy) state_n = ret_state;
      end

      default: state_n = S_ANNOUNCE;
    endcase
  end

  // State, timers, frame buffers and registered outputs.
  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      state      <= S_ANNOUNCE;
      ret_state  <= S_IDLE;
      idx        <= '0;
      btmr       <= '0;
      wtmr       <= '0;
      verb_buf   <= '0;
      arg_buf    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      disp_start <= 1'b0;
      disp_count <= '0;
      verb_out   <= '0;
      args_out   <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_state_n;
      idx        <= idx_n;
      btmr       <= btmr_n;
      wtmr       <= wtmr_n;
      verb_buf   <= verb_buf_n;
      arg_buf    <= arg_buf_n;
      tx_start   <= tx_start_n;
      tx_data    <= tx_data_n;
      disp_start <= disp_start_n;
      disp_count <= disp_count_n;
      verb_out   <= verb_out_n;
      args_out   <= args_out_n;
      frame_err  <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_cmd_frame_engine.sv
// Scoreboard bench for cmd_frame_engine: stimulus pushes expected reply bytes and
// dispatch words, and a monitor pops and compares them when the DUT presents them.
module tb_cmd_frame_engine;

  localparam logic [3:0] ST_ANNOUNCE  = 4'd0;
  localparam logic [3:0] ST_IDLE      = 4'd1;
  localparam logic [3:0] ST_WAIT_DISP = 4'd6;

  typedef struct packed {
    logic [7:0] code;
    logic       err;
  } tx_exp_t;

  logic        clk50m = 1'b0;
  logic        reset;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        disp_start;
  logic [23:0] disp_count;
  logic [2:0]  disp_done;
  logic [7:0]  verb_out;
  logic [23:0] args_out;
  logic [3:0]  state_out;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  tx_exp_t     exp_tx[$];
  logic [23:0] exp_disp[$];

  cmd_frame_engine #(
    .N_ARGS(3), .N_CH(3), .BYTE_TIMEOUT(100), .DISP_TIMEOUT(1000),
    .V_PING(8'h02), .V_GO(8'h06)
  ) dut (
    .clk50m(clk50m), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .disp_start(disp_start), .disp_count(disp_count), .disp_done(disp_done),
    .verb_out(verb_out), .args_out(args_out), .state_out(state_out),
    .frame_err(frame_err)
  );

  always #10 clk50m = ~clk50m;

  // UART transmitter model: busy for 10 cycles after each tx_start.
  always @(posedge clk50m) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor: compare every presented reply byte and dispatch against the queues.
  always @(negedge clk50m) begin
    tx_exp_t e;
    logic [23:0] d;
    if (tx_start) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got tx_data=%02h err=%0b, required no transmission", tx_data, frame_err);
      end else begin
        e = exp_tx.pop_front();
        if (tx_data !== e.code || frame_err !== e.err) begin
          errors++;
          $display("FAIL tx_byte: got %02h err=%0b, required %02h err=%0b", tx_data, frame_err, e.code, e.err);
        end
      end
    end else if (frame_err) begin
      checks++;
      errors++;
      $display("FAIL frame_err_alone: got frame_err=1 without tx_start, required 0");
    end
    if (disp_start) begin
      checks++;
      if (exp_disp.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: got disp_start with count %06h, required none", disp_count);
      end else begin
        d = exp_disp.pop_front();
        if (disp_count !== d) begin
          errors++;
          $display("FAIL disp_count: got %06h, required %06h", disp_count, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_tx(input logic [7:0] code, input logic err);
    tx_exp_t e;
    e.code = code;
    e.err  = err;
    exp_tx.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk50m);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk50m);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk50m);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic [7:0] a0,
                            input logic [7:0] a1, input logic [7:0] a2);
    send_byte(v);
    send_byte(a0);
    send_byte(a1);
    send_byte(a2);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n = 0;
    while (state_out !== s && n < budget) begin
      @(negedge clk50m);
      n++;
    end
    checks++;
    if (state_out !== s) begin
      errors++;
      $display("FAIL %s: state_out=%0d after %0d cycles, required %0d", name, state_out, n, s);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_disp_start"}, {31'd0, disp_start}, 32'd0);
    check({tag, "_disp_count"}, {8'd0, disp_count}, 32'd0);
    check({tag, "_verb_out"}, {24'd0, verb_out}, 32'd0);
    check({tag, "_args_out"}, {8'd0, args_out}, 32'd0);
    check({tag, "_state_out"}, {28'd0, state_out}, {28'd0, ST_ANNOUNCE});
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    disp_done = 3'b000;
    repeat (3) @(negedge clk50m);
    check_reset_outputs("reset");

    // Release: one HELLO byte, then IDLE.
    push_tx(8'h01, 1'b0);
    @(negedge clk50m);
    reset = 1'b1;
    wait_state(ST_IDLE, 100, "announce_to_idle");

    // PING frame.
    push_tx(8'h05, 1'b0);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00);
    wait_state(ST_IDLE, 100, "ping_done");
    check("ping_verb_out", {24'd0, verb_out}, 32'h02);

    // GO frame with all channels finishing; a byte sent during WAIT_DISP is dropped.
    exp_disp.push_back(24'h020103);
    push_tx(8'h04, 1'b0);
    push_tx(8'h06, 1'b0);
    send_frame(8'h06, 8'h03, 8'h01, 8'h02);
    wait_state(ST_WAIT_DISP, 200, "go_wait_disp");
    send_byte(8'h02);
    push_tx(8'h03, 1'b0);
    push_tx(8'h00, 1'b0);
    disp_done = 3'b111;
    wait_state(ST_IDLE, 200, "go_done");
    disp_done = 3'b000;
    check("go_args_out", {8'd0, args_out}, 32'h020103);
    check("go_verb_out", {24'd0, verb_out}, 32'h06);

    // Truncated frame times out: NAK, frame registers unchanged.
    push_tx(8'h0F, 1'b1);
    send_byte(8'h06);
    send_byte(8'h05);
    wait_state(ST_IDLE, 300, "timeout_nak");
    check("timeout_args_kept", {8'd0, args_out}, 32'h020103);
    check("timeout_verb_kept", {24'd0, verb_out}, 32'h06);
    push_tx(8'h05, 1'b0);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00);
    wait_state(ST_IDLE, 100, "ping_after_timeout");
    check("ping2_args_out", {8'd0, args_out}, 32'h000000);

    // Unknown verb.
    push_tx(8'h0F, 1'b1);
    send_frame(8'h7A, 8'h00, 8'h00, 8'h00);
    wait_state(ST_IDLE, 100, "bad_verb_nak");
    check("bad_verb_out", {24'd0, verb_out}, 32'h7A);

    // Watchdog expiry with disp_done held low.
    exp_disp.push_back(24'h030201);
    push_tx(8'h04, 1'b0);
    push_tx(8'h06, 1'b0);
    send_frame(8'h06, 8'h01, 8'h02, 8'h03);
    wait_state(ST_WAIT_DISP, 200, "wd_wait_disp");
    push_tx(8'h0F, 1'b1);
    n = 0;
    while (state_out === ST_WAIT_DISP && n < 2000) begin
      @(negedge clk50m);
      n++;
    end
    checks++;
    if (n < 990 || n > 1010) begin
      errors++;
      $display("FAIL wd_duration: got %0d cycles in WAIT_DISP, required about 1000", n);
    end
    wait_state(ST_IDLE, 100, "wd_to_idle");

    // Reset in the middle of WAIT_DISP.
    exp_disp.push_back(24'h090807);
    push_tx(8'h04, 1'b0);
    push_tx(8'h06, 1'b0);
    send_frame(8'h06, 8'h07, 8'h08, 8'h09);
    wait_state(ST_WAIT_DISP, 200, "rst_wait_disp");
    repeat (20) @(negedge clk50m);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    push_tx(8'h01, 1'b0);
    @(negedge clk50m);
    reset = 1'b1;
    wait_state(ST_IDLE, 100, "reannounce_idle");

    repeat (5) @(negedge clk50m);
    check("tx_queue_drained", exp_tx.size(), 32'd0);
    check("disp_queue_drained", exp_disp.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
